stage_ex_mul: RTL
=================

Name: stage_ex_mul

Overview:
Execute stage directly upstream of the memory-access stage in the RV32 turbo pipeline. It accepts one decoded instruction per handshake and computes one of two results:
- single-cycle ALU/shift ops, or
- RV32M MUL/MULH/MULHSU/MULHU on an iterative radix-2 shift-add multiplier.

It registers the result plus pass-through memory-control fields, and presents them to the MA stage as a one-cycle Done pulse. The pulse is issued only when MA can accept it.

Parameters:
MUL_ITER, 32, multiplier iteration count (fixed at the operand width; not to be changed).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
PC_I  in  32  instruction PC from ID
Done_I  in  1  ID has valid instruction this cycle
A_I  in  32  operand A (rs1 value)
B_I  in  32  operand B (rs2 value or immediate)
ALU_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; 11-15 yield 0
Is_Mul  in  1  instruction is RV32M multiply
Mul_Fn  in  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
Mem_Ctrl_I  in  6  {MemWrite, MemRead, Write_strb}, passed through
Mem_wdata_I  in  32  store data, passed through
RF_waddr_I  in  5  destination register
Funct3_I  in  3  funct3, passed through
MA_Busy  in  1  high whenever MA cannot accept Done (every MA state except idle wait)
PC_O  out  32  registered PC
Done_O  out  1  one-cycle valid pulse to MA
Result_O  out  32  ALU/multiply result; also memory address for loads/stores
Mem_Ctrl_O  out  6  registered Mem_Ctrl_I
Mem_wdata_O  out  32  registered Mem_wdata_I
RF_waddr_O  out  5  registered RF_waddr_I
Funct3_O  out  3  registered Funct3_I
Feedback_EX_Busy  out  1  stall to ID: (!rst) && state != s_IDLE

Behaviour:
- States (one-hot): s_IDLE, s_MUL, s_OUT.
- Reset values: state s_IDLE, Done_O 0, RF_waddr_O 0, Mem_Ctrl_O 0. Other data registers are don't-care.
- s_IDLE, Done_I=1 (accept edge E0):
  - Latch PC, Mem_Ctrl, Mem_wdata, RF_waddr, Funct3.
  - If Is_Mul=0: Result_O <= ALU(A_I,B_I); go to s_OUT.
  - If Is_Mul=1: go to s_MUL and initialise the multiplier.
- s_IDLE, Done_I=0: stay.
- Done_I is ignored in every state other than s_IDLE. ID must not pulse Done_I while Feedback_EX_Busy=1.
- ALU rules:
  - Shifts use B[4:0]; SRA is arithmetic.
  - SLT is signed and SLTU unsigned; both give 0/1 zero-extended.
  - Add/sub wrap modulo 2^32.
- Multiplier init:
  - sA = A[31] for MULH/MULHSU; sB = B[31] for MULH only.
  - Multiplicand reg = |A| if sA, else A. Multiplier reg = |B| if sB, else B.
  - 64-bit accumulator = 0; 5-bit counter = 0; Neg = sA^sB.
  - |0x80000000| = 0x80000000, treated as unsigned.
- s_MUL, each cycle:
  - If multiplier[0]=1, add multiplicand<<counter into the accumulator.
  - Shift multiplier right by 1; counter++.
  - After the counter=31 cycle, go to s_OUT. On that edge, P = Neg ? -acc : acc (64-bit two's complement), and Result_O <= (Mul_Fn==MUL) ? P[31:0] : P[63:32].
  - Mul_Fn is held in a register captured at E0.
- s_OUT:
  - If MA_Busy=0: Done_O <= 1 and go to s_IDLE.
  - Else stay, with outputs stable.
  - Done_O is 0 in all other cycles.
- Latency:
  - ALU op: Done_O high in the cycle after E1 (MA_Busy=0).
  - Multiply: state is s_MUL from E0 to E32, s_OUT at E32, Done_O high after E33.
- Back-to-back: during the Done_O cycle the state is s_IDLE and may accept a new instruction. Output registers update on the same edge at which MA samples the old values, which is legal.
- MA_Busy rising while in s_OUT: stall indefinitely, with no lost or duplicated Done_O.
- rst mid-multiply or in s_OUT: immediately return to s_IDLE. Done_O=0, Feedback_EX_Busy=0 in the reset cycle, and the partial result is discarded.

Optional Feature:
MUL_EARLY_OUT_EN:
- Defined: in s_MUL, if the shifted multiplier register becomes zero, go to s_OUT at that edge (final sign-fix applied). Multiply latency = 1 + index of the highest set bit of |B|. If |B|=0 at init, go s_IDLE→s_OUT directly with result 0, giving ALU latency.
- Undefined: always 32 iterations.
- Results must be identical either way.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, MA_Busy=0 -> Result_O=0x80000000, Done_O one cycle after E1, Feedback_EX_Busy high exactly one cycle.
- SRA A=0x80000000, B=0x1F; then SLTU A=1, B=0xFFFFFFFF -> 0xFFFFFFFF then 0x00000001, issued back-to-back.
- A=0xFFFFFFFF, B=2 with MUL/MULH/MULHSU/MULHU -> 0xFFFFFFFE / 0xFFFFFFFF / 0xFFFFFFFF / 0x00000001; Done_O after E33 (macro off).
- MULH A=B=0x80000000 -> 0x40000000; MUL -> 0x00000000.
- Load op (Mem_Ctrl_I=0x1F), MA_Busy=1 for 5 cycles in s_OUT -> Done_O withheld, single pulse after MA_Busy falls, Mem_Ctrl_O=0x1F, outputs stable throughout.
- rst asserted at iteration 10 of MULHU -> next cycle s_IDLE, Done_O=0, Feedback_EX_Busy=0; next ADD completes normally. With MUL_EARLY_OUT_EN, MUL B=3 -> Done_O after E3.

Source files
------------

// File: rtl/stage_ex_mul_if.sv
// ID/EX/MA signal bundle for the RV32 execute stage (stage_ex_mul).
// slave: the execute stage itself; master: the surrounding ID/MA side.
interface stage_ex_mul_if;
    logic [31:0] PC_I;
    logic        Done_I;
    logic [31:0] A_I;
    logic [31:0] B_I;
    logic [3:0]  ALU_op;
    logic        Is_Mul;
    logic [1:0]  Mul_Fn;
    logic [5:0]  Mem_Ctrl_I;
    logic [31:0] Mem_wdata_I;
    logic [4:0]  RF_waddr_I;
    logic [2:0]  Funct3_I;
    logic        MA_Busy;

    logic [31:0] PC_O;
    logic        Done_O;
    logic [31:0] Result_O;
    logic [5:0]  Mem_Ctrl_O;
    logic [31:0] Mem_wdata_O;
    logic [4:0]  RF_waddr_O;
    logic [2:0]  Funct3_O;
    logic        Feedback_EX_Busy;

    modport slave (
        input  PC_I, Done_I, A_I, B_I, ALU_op, Is_Mul, Mul_Fn,
               Mem_Ctrl_I, Mem_wdata_I, RF_waddr_I, Funct3_I, MA_Busy,
        output PC_O, Done_O, Result_O, Mem_Ctrl_O, Mem_wdata_O,
               RF_waddr_O, Funct3_O, Feedback_EX_Busy
    );

    modport master (
        output PC_I, Done_I, A_I, B_I, ALU_op, Is_Mul, Mul_Fn,
               Mem_Ctrl_I, Mem_wdata_I, RF_waddr_I, Funct3_I, MA_Busy,
        input  PC_O, Done_O, Result_O, Mem_Ctrl_O, Mem_wdata_O,
               RF_waddr_O, Funct3_O, Feedback_EX_Busy
    );
endinterface

// File: rtl/stage_ex_mul.sv
// RV32 execute stage: single-cycle ALU plus iterative radix-2 RV32M multiplier.
// Optional MUL_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module stage_ex_mul #(
    parameter int MUL_ITER = 32
) (
    input  logic               clk,
    input  logic               rst,
    stage_ex_mul_if.slave      bus,
    output logic [2:0]         o_dbg_state
);
    // Handshake: Done_I is sampled only in s_IDLE (ID holds off while
    // Feedback_EX_Busy=1); Done_O is a one-cycle pulse issued only when MA_Busy=0.

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_MUL  = 3'b010,
        S_OUT  = 3'b100
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(MUL_ITER - 1);

    state_t      r_state;
    logic        r_done;
    logic [31:0] r_pc;
    logic [31:0] r_result;
    logic [5:0]  r_mem_ctrl;
    logic [31:0] r_mem_wdata;
    logic [4:0]  r_waddr;
    logic [2:0]  r_funct3;

    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic [1:0]  r_fn;

    logic [31:0] w_alu;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_addend;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;
    logic [31:0] w_mplier_next;
    logic        w_mul_last;

    always_comb begin
        w_alu = 32'd0;
        case (bus.ALU_op)
            4'd0:  w_alu = bus.A_I + bus.B_I;
            4'd1:  w_alu = bus.A_I - bus.B_I;
            4'd2:  w_alu = bus.A_I << bus.B_I[4:0];
            4'd3:  w_alu = {31'd0, $signed(bus.A_I) < $signed(bus.B_I)};
            4'd4:  w_alu = {31'd0, bus.A_I < bus.B_I};
            4'd5:  w_alu = bus.A_I ^ bus.B_I;
            4'd6:  w_alu = bus.A_I >> bus.B_I[4:0];
            4'd7:  w_alu = $unsigned($signed(bus.A_I) >>> bus.B_I[4:0]);
            4'd8:  w_alu = bus.A_I | bus.B_I;
            4'd9:  w_alu = bus.A_I & bus.B_I;
            4'd10: w_alu = bus.B_I;
            default: w_alu = 32'd0;
        endcase
    end

    // Operands are reduced to magnitudes; the sign is reapplied on the final edge.
    // |0x80000000| stays 0x80000000 and is read as unsigned.
    assign w_sa    = ((bus.Mul_Fn == 2'd1) || (bus.Mul_Fn == 2'd2)) && bus.A_I[31];
    assign w_sb    = (bus.Mul_Fn == 2'd1) && bus.B_I[31];
    assign w_abs_a = w_sa ? (32'd0 - bus.A_I) : bus.A_I;
    assign w_abs_b = w_sb ? (32'd0 - bus.B_I) : bus.B_I;

    assign w_addend      = r_mplier[0] ? ({32'd0, r_mcand} << r_cnt) : 64'd0;
    assign w_acc_next    = r_acc + w_addend;
    assign w_prod        = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_mul_res     = (r_fn == 2'd0) ? w_prod[31:0] : w_prod[63:32];
    assign w_mplier_next = {1'b0, r_mplier[31:1]};

`ifdef MUL_EARLY_OUT_EN
    assign w_mul_last = (r_cnt == LAST_CNT) || (w_mplier_next == 32'd0);
`else
    assign w_mul_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_waddr    <= 5'd0;
            r_mem_ctrl <= 6'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Done_I) begin
                        r_pc        <= bus.PC_I;
                        r_mem_ctrl  <= bus.Mem_Ctrl_I;
                        r_mem_wdata <= bus.Mem_wdata_I;
                        r_waddr     <= bus.RF_waddr_I;
                        r_funct3    <= bus.Funct3_I;
                        r_fn        <= bus.Mul_Fn;
                        if (!bus.Is_Mul) begin
                            r_result <= w_alu;
                            r_state  <= S_OUT;
                        end else begin
                            r_mcand  <= w_abs_a;
                            r_mplier <= w_abs_b;
                            r_acc    <= 64'd0;
                            r_cnt    <= 5'd0;
                            r_neg    <= w_sa ^ w_sb;
`ifdef MUL_EARLY_OUT_EN
                            if (w_abs_b == 32'd0) begin
                                r_result <= 32'd0;
                                r_state  <= S_OUT;
                            end else begin
                                r_state  <= S_MUL;
                            end
`else
                            r_state  <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_mul_last) begin
                        r_result <= w_mul_res;
                        r_state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (!bus.MA_Busy) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.PC_O             = r_pc;
    assign bus.Done_O           = r_done;
    assign bus.Result_O         = r_result;
    assign bus.Mem_Ctrl_O       = r_mem_ctrl;
    assign bus.Mem_wdata_O      = r_mem_wdata;
    assign bus.RF_waddr_O       = r_waddr;
    assign bus.Funct3_O         = r_funct3;
    assign bus.Feedback_EX_Busy = !rst && (r_state != S_IDLE);
    assign o_dbg_state          = r_state;

endmodule
